// File: rtl/led_pattern_gen.sv
// led_pattern_gen: tick-paced LED pattern generator with programmable step count and completion pulse
module led_pattern_gen #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             timer,
  output logic [WIDTH-1:0] outputbits,
  output logic             busy,
  output logic             timeout
);
  localparam int IDX_W = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] n_q, k;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] fill, fill_n, alt, pat;
  logic go, empty_start, tick, done, abort;
  for (genvar i = 0; i < WIDTH; i++) begin : g_alt
    assign alt[i] = (i % 2 == 0);
  end
  // Next-state decode; the k==N tick ends the run, stop overrides any tick
  always_comb begin
    state_n     = state;
    go          = 1'b0;
    empty_start = 1'b0;
    tick        = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    if (state == IDLE) begin
      go          = start && num_steps != '0;
      empty_start = start && num_steps == '0;
      state_n     = go ? RUN : IDLE;
    end else begin
      abort   = stop;
      done    = !stop && timer && k == n_q;
      tick    = !stop && timer && k != n_q;
      state_n = (abort || done) ? IDLE : RUN;
    end
  end
  // Pattern for step k+1: odd steps are those where k is even
  always_comb begin
    idx_n  = (idx == IDX_W'(WIDTH - 1)) ? '0 : idx + IDX_W'(1);
    fill_n = &fill ? '0 : {fill[WIDTH-2:0], 1'b1};
    pat    = mode_q == 2'd0 ? {WIDTH{~k[0]}} :
             mode_q == 2'd1 ? (k[0] ? ~alt : alt) :
             mode_q == 2'd2 ? WIDTH'(1) << idx : fill_n;
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end
  // Datapath: latch run parameters on start, advance on ticks, clear on end or abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= '0;
      n_q        <= '0;
      k          <= '0;
      idx        <= '0;
      fill       <= '0;
      outputbits <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= empty_start || done;
      if (go) begin
        mode_q     <= mode;
        n_q        <= num_steps;
        k          <= '0;
        idx        <= '0;
        fill       <= '0;
        outputbits <= '0;
        busy       <= 1'b1;
      end else if (done || abort) begin
        outputbits <= '0;
        busy       <= 1'b0;
      end else if (tick) begin
        k          <= k + CNT_W'(1);
        idx        <= idx_n;
        fill       <= fill_n;
        outputbits <= pat;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard-driven bench for led_pattern_gen at WIDTH=10, CNT_W=4
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, timer = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] num_steps = '0;
  logic [9:0] outputbits;
  logic       busy, timeout;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  int tests = 0, fails = 0;

  led_pattern_gen #(.WIDTH(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .num_steps(num_steps), .timer(timer), .outputbits(outputbits),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [1:0] m, input int s);
    case (m)
      2'd0:    return (s % 2 == 1) ? 10'h3FF : 10'h000;
      2'd1:    return (s % 2 == 1) ? 10'h155 : 10'h2AA;
      2'd2:    return 10'(32'd1 << ((s - 1) % 10));
      default: return 10'((32'd1 << (s % 11)) - 32'd1);
    endcase
  endfunction

  task automatic pulse_timer;
    @(negedge clk) timer = 1'b1;
    @(negedge clk) timer = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [3:0] n);
    @(negedge clk) begin start = 1'b1; mode = m; num_steps = n; end
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests += 3;
    if (outputbits !== 10'h000) begin fails++; $display("FAIL reset_out got %h exp 000", outputbits); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_patterns;
    logic [1:0] ms[4] = '{2'd0, 2'd2, 2'd3, 2'd1};
    int         ns[4] = '{3, 12, 12, 2};
    for (int t = 0; t < 4; t++) begin
      do_start(ms[t], 4'(ns[t]));
      mode = ~ms[t];
      num_steps = 4'd1;
      tests += 2;
      if (busy !== 1'b1) begin fails++; $display("FAIL start_busy m%0d got %b exp 1", ms[t], busy); end
      if (outputbits !== 10'h000) begin fails++; $display("FAIL start_out m%0d got %h exp 000", ms[t], outputbits); end
      for (int s = 1; s <= ns[t]; s++) begin
        exp_q.push_back(model(ms[t], s));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulse_timer();
        e = exp_q.pop_front();
        tests += 3;
        if (outputbits !== e) begin fails++; $display("FAIL pat m%0d s%0d got %h exp %h", ms[t], s, outputbits, e); end
        if (busy !== 1'b1) begin fails++; $display("FAIL run_busy m%0d s%0d got %b exp 1", ms[t], s, busy); end
        if (timeout !== 1'b0) begin fails++; $display("FAIL run_timeout m%0d s%0d got %b exp 0", ms[t], s, timeout); end
      end
      exp_q.push_back(10'h000);
      pulse_timer();
      e = exp_q.pop_front();
      tests += 3;
      if (outputbits !== e) begin fails++; $display("FAIL end_out m%0d got %h exp %h", ms[t], outputbits, e); end
      if (busy !== 1'b0) begin fails++; $display("FAIL end_busy m%0d got %b exp 0", ms[t], busy); end
      if (timeout !== 1'b1) begin fails++; $display("FAIL end_timeout m%0d got %b exp 1", ms[t], timeout); end
      @(negedge clk);
      tests++;
      if (timeout !== 1'b0) begin fails++; $display("FAIL end_pulse_len m%0d got %b exp 0", ms[t], timeout); end
    end
  endtask

  task automatic test_zero_start;
    do_start(2'd0, 4'd0);
    tests += 3;
    if (timeout !== 1'b1) begin fails++; $display("FAIL zero_timeout got %b exp 1", timeout); end
    if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got %b exp 0", busy); end
    if (outputbits !== 10'h000) begin fails++; $display("FAIL zero_out got %h exp 000", outputbits); end
    @(negedge clk);
    tests += 2;
    if (timeout !== 1'b0) begin fails++; $display("FAIL zero_pulse_len got %b exp 0", timeout); end
    if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy2 got %b exp 0", busy); end
  endtask

  task automatic test_start_timer;
    @(negedge clk) begin start = 1'b1; timer = 1'b1; mode = 2'd2; num_steps = 4'd2; end
    @(negedge clk) begin start = 1'b0; timer = 1'b0; end
    tests += 2;
    if (busy !== 1'b1) begin fails++; $display("FAIL st_busy got %b exp 1", busy); end
    if (outputbits !== 10'h000) begin fails++; $display("FAIL st_out got %h exp 000", outputbits); end
    exp_q.push_back(model(2'd2, 1));
    pulse_timer();
    e = exp_q.pop_front();
    tests++;
    if (outputbits !== e) begin fails++; $display("FAIL st_first got %h exp %h", outputbits, e); end
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL st_abort_busy got %b exp 0", busy); end
  endtask

  task automatic test_stop;
    do_start(2'd0, 4'd8);
    for (int s = 1; s <= 4; s++) begin
      exp_q.push_back(model(2'd0, s));
      if (s == 2) begin
        @(negedge clk) begin start = 1'b1; mode = 2'd2; num_steps = 4'd1; end
        @(negedge clk) start = 1'b0;
      end
      pulse_timer();
      e = exp_q.pop_front();
      tests += 2;
      if (outputbits !== e) begin fails++; $display("FAIL stop_pre s%0d got %h exp %h", s, outputbits, e); end
      if (busy !== 1'b1) begin fails++; $display("FAIL stop_pre_busy s%0d got %b exp 1", s, busy); end
    end
    @(negedge clk) begin stop = 1'b1; timer = 1'b1; end
    @(negedge clk) begin stop = 1'b0; timer = 1'b0; end
    tests += 3;
    if (outputbits !== 10'h000) begin fails++; $display("FAIL stop_out got %h exp 000", outputbits); end
    if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy got %b exp 0", busy); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL stop_timeout got %b exp 0", timeout); end
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    tests += 2;
    if (timeout !== 1'b0) begin fails++; $display("FAIL stop_idle_timeout got %b exp 0", timeout); end
    if (busy !== 1'b0) begin fails++; $display("FAIL stop_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_async_reset;
    do_start(2'd3, 4'd5);
    pulse_timer();
    pulse_timer();
    tests++;
    if (outputbits !== 10'h003) begin fails++; $display("FAIL ar_pre got %h exp 003", outputbits); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    tests += 2;
    if (outputbits !== 10'h000) begin fails++; $display("FAIL ar_out got %h exp 000", outputbits); end
    if (busy !== 1'b0) begin fails++; $display("FAIL ar_busy got %b exp 0", busy); end
    @(negedge clk) rst = 1'b1;
    do_start(2'd1, 4'd2);
    for (int s = 1; s <= 2; s++) begin
      exp_q.push_back(model(2'd1, s));
      pulse_timer();
      e = exp_q.pop_front();
      tests++;
      if (outputbits !== e) begin fails++; $display("FAIL ar_post s%0d got %h exp %h", s, outputbits, e); end
    end
    pulse_timer();
    tests++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL ar_post_timeout got %b exp 1", timeout); end
  endtask

  task automatic test_back_to_back;
    do_start(2'd0, 4'd1);
    pulse_timer();
    pulse_timer();
    tests++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL b2b_timeout got %b exp 1", timeout); end
    start = 1'b1; mode = 2'd2; num_steps = 4'd1;
    @(negedge clk) start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b exp 1", busy); end
    exp_q.push_back(model(2'd2, 1));
    pulse_timer();
    e = exp_q.pop_front();
    tests++;
    if (outputbits !== e) begin fails++; $display("FAIL b2b_out got %h exp %h", outputbits, e); end
    pulse_timer();
    tests++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL b2b_end got %b exp 1", timeout); end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_zero_start();
    test_start_timer();
    test_stop();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
